hazard_ctrl: RTL and testbench

Pipeline hazard controller for the RV32I core. It keeps a two-deep shadow scoreboard of in-flight destination registers. From that scoreboard it generates, one cycle ahead, the forwarding controls consumed by the EX-stage operand forwarding unit (`is_hazard1/2`, `hazard_reg1/2`), and it sequences pipeline stalls, load-use bubbles and branch flushes. It sits beside the ID stage and drives the IF/ID/EX pipeline-register enables.

---
 rtl/hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the RV32I pipeline: two-slot destination scoreboard,
// registered EX forwarding controls, and stall / bubble / flush sequencing.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic [6:0]       id_op,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             is_hazard1,
    output logic             is_hazard2,
    output logic [2:0]       hazard_reg1,
    output logic [2:0]       hazard_reg2,
    output logic             dup_src,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_LOAD = 7'b0000011;

    typedef enum logic {
        ST_RUN,
        ST_MEMWAIT
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic       r_d1_valid;
    logic [4:0] r_d1_rd;
    logic       r_d1_load;
    logic       r_d2_valid;
    logic [4:0] r_d2_rd;

    logic       r_is_hazard1;
    logic       r_is_hazard2;
    logic [2:0] r_hazard_reg1;
    logic [2:0] r_hazard_reg2;
    logic       r_dup_src;
    logic [CNT_W-1:0] r_stall_cnt;

    logic       w_m1a;
    logic       w_m1b;
    logic       w_m2a;
    logic       w_m2b;
    logic       w_need2a;
    logic       w_need2b;
    logic       w_same_src;
    logic       w_load_use;
    logic       w_freeze;
    logic       w_advance;
    logic       w_issue;
    logic       w_fwd_h1;
    logic       w_fwd_h2;
    logic [2:0] w_fwd_r1;
    logic [2:0] w_fwd_r2;
    logic       w_fwd_dup;

    // Slot validity already excludes rd == 0; the extra x0 guard keeps that explicit.
    always_comb begin
        w_m1a = r_d1_valid & id_use_rs1 & (id_rs1 == r_d1_rd) & (id_rs1 != 5'd0);
        w_m1b = r_d1_valid & id_use_rs2 & (id_rs2 == r_d1_rd) & (id_rs2 != 5'd0);
        w_m2a = r_d2_valid & id_use_rs1 & (id_rs1 == r_d2_rd) & (id_rs1 != 5'd0);
        w_m2b = r_d2_valid & id_use_rs2 & (id_rs2 == r_d2_rd) & (id_rs2 != 5'd0);
        w_need2a   = w_m2a & ~w_m1a;
        w_need2b   = w_m2b & ~w_m1b;
        w_same_src = id_use_rs1 & id_use_rs2 & (id_rs1 == id_rs2);
        w_load_use = r_d1_load & (w_m1a | w_m1b);

        w_fwd_h1  = w_m1a | w_m1b;
        w_fwd_r1  = w_m1a ? 3'd1 : (w_m1b ? 3'd2 : 3'd0);
        w_fwd_h2  = w_need2a | w_need2b;
        w_fwd_r2  = w_need2a ? 3'd3 : (w_need2b ? 3'd4 : 3'd0);
        w_fwd_dup = w_same_src & (w_m1a | w_m2a);
    end

    always_comb begin
        w_next_state = r_state;
        w_freeze     = 1'b0;
        w_advance    = 1'b0;
        w_issue      = 1'b0;
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        bubble_ex    = 1'b0;
        flush_id     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (mem_busy) begin
                    w_next_state = ST_MEMWAIT;
                    w_freeze     = 1'b1;
                end
            end
            ST_MEMWAIT: begin
                if (mem_busy) begin
                    w_freeze = 1'b1;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            default: w_next_state = ST_RUN;
        endcase
        // Reset overrides everything, including a pending memory freeze.
        if (!rst) begin
            if (w_freeze) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
            end else begin
                w_advance = 1'b1;
                if (branch_taken) begin
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                end else if (w_load_use) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end else begin
                    w_issue = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_d1_valid <= 1'b0;
            r_d1_rd    <= 5'd0;
            r_d1_load  <= 1'b0;
            r_d2_valid <= 1'b0;
            r_d2_rd    <= 5'd0;
        end else begin
            r_state <= w_next_state;
            if (w_advance) begin
                r_d2_valid <= r_d1_valid;
                r_d2_rd    <= r_d1_rd;
                r_d1_valid <= w_issue & id_regwrite & (id_rd != 5'd0);
                r_d1_rd    <= id_rd;
                r_d1_load  <= w_issue & (id_op == OP_LOAD);
            end
        end
    end

    // Codes registered on a bubble cycle are zero so the NOP in EX forwards nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_hazard1  <= 1'b0;
            r_is_hazard2  <= 1'b0;
            r_hazard_reg1 <= 3'd0;
            r_hazard_reg2 <= 3'd0;
            r_dup_src     <= 1'b0;
        end else if (w_advance) begin
            r_is_hazard1  <= w_issue & w_fwd_h1;
            r_is_hazard2  <= w_issue & w_fwd_h2;
            r_hazard_reg1 <= w_issue ? w_fwd_r1 : 3'd0;
            r_hazard_reg2 <= w_issue ? w_fwd_r2 : 3'd0;
            r_dup_src     <= w_issue & w_fwd_dup;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((stall_if | bubble_ex) && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign is_hazard1  = r_is_hazard1;
    assign is_hazard2  = r_is_hazard2;
    assign hazard_reg1 = r_hazard_reg1;
    assign hazard_reg2 = r_hazard_reg2;
    assign dup_src     = r_dup_src;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: operand-distance reference model compared
// every cycle, plus hand-computed checks on the key scenarios.
module tb_hazard_ctrl;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_ALU  = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam int CNT_MAX  = 65535;
    localparam int CNT2_MAX = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       id_use_rs1 = 1'b0;
    logic       id_use_rs2 = 1'b0;
    logic [4:0] id_rd = '0;
    logic       id_regwrite = 1'b0;
    logic [6:0] id_op = '0;
    logic       branch_taken = 1'b0;
    logic       mem_busy = 1'b0;

    logic        is_hazard1, is_hazard2, dup_src;
    logic [2:0]  hazard_reg1, hazard_reg2;
    logic        stall_if, stall_id, bubble_ex, flush_id;
    logic [15:0] stall_cnt;

    logic        b_is_hazard1, b_is_hazard2, b_dup_src;
    logic [2:0]  b_hazard_reg1, b_hazard_reg2;
    logic        b_stall_if, b_stall_id, b_bubble_ex, b_flush_id;
    logic [1:0]  b_stall_cnt;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_op(id_op),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .is_hazard1(is_hazard1), .is_hazard2(is_hazard2),
        .hazard_reg1(hazard_reg1), .hazard_reg2(hazard_reg2),
        .dup_src(dup_src), .stall_if(stall_if), .stall_id(stall_id),
        .bubble_ex(bubble_ex), .flush_id(flush_id), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.CNT_W(2)) dutSmall (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_op(id_op),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .is_hazard1(b_is_hazard1), .is_hazard2(b_is_hazard2),
        .hazard_reg1(b_hazard_reg1), .hazard_reg2(b_hazard_reg2),
        .dup_src(b_dup_src), .stall_if(b_stall_if), .stall_id(b_stall_id),
        .bubble_ex(b_bubble_ex), .flush_id(b_flush_id), .stall_cnt(b_stall_cnt)
    );

    always #5 clk = ~clk;

    // Model: destination of the instruction in EX and in MEM (0 = none).
    int exRd = 0, memRd = 0, nExRd = 0, nMemRd = 0;
    bit exLoad = 0, nExLoad = 0;
    int eH1 = 0, eR1 = 0, eH2 = 0, eR2 = 0, eDup = 0;
    int nH1 = 0, nR1 = 0, nH2 = 0, nR2 = 0, nDup = 0;
    int eSIf = 0, eSId = 0, eBub = 0, eFl = 0;
    int eCnt = 0, eCnt2 = 0, nCnt = 0, nCnt2 = 0;
    int nCompared = 0;
    int nMismatch = 0;
    bit checkEn = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int distOf(input int src, input bit used);
        if (!used || src == 0) return 0;
        if (src == exRd) return 1;
        if (src == memRd) return 2;
        return 0;
    endfunction

    task automatic computeCycle();
        int da;
        int db;
        da = distOf(int'(id_rs1), id_use_rs1);
        db = distOf(int'(id_rs2), id_use_rs2);
        nExRd = exRd; nMemRd = memRd; nExLoad = exLoad;
        nH1 = eH1; nR1 = eR1; nH2 = eH2; nR2 = eR2; nDup = eDup;
        eSIf = 0; eSId = 0; eBub = 0; eFl = 0;
        if (mem_busy) begin
            eSIf = 1; eSId = 1;
        end else begin
            nMemRd = exRd;
            nH1 = 0; nR1 = 0; nH2 = 0; nR2 = 0; nDup = 0;
            nExRd = 0; nExLoad = 0;
            if (branch_taken) begin
                eFl = 1; eBub = 1;
            end else if (exLoad && (da == 1 || db == 1)) begin
                eSIf = 1; eSId = 1; eBub = 1;
            end else begin
                nExRd   = id_regwrite ? int'(id_rd) : 0;
                nExLoad = (id_op == OP_LOAD) && (nExRd != 0);
                nH1 = (da == 1 || db == 1) ? 1 : 0;
                nR1 = (da == 1) ? 1 : ((db == 1) ? 2 : 0);
                nH2 = (da == 2 || db == 2) ? 1 : 0;
                nR2 = (da == 2) ? 3 : ((db == 2) ? 4 : 0);
                nDup = (id_use_rs1 && id_use_rs2 && id_rs1 == id_rs2 && da != 0) ? 1 : 0;
            end
        end
        nCnt  = eCnt;
        nCnt2 = eCnt2;
        if (eSIf == 1 || eBub == 1) begin
            if (eCnt < CNT_MAX) nCnt = eCnt + 1;
            if (eCnt2 < CNT2_MAX) nCnt2 = eCnt2 + 1;
        end
    endtask

    task automatic commitModel();
        exRd = nExRd; memRd = nMemRd; exLoad = nExLoad;
        eH1 = nH1; eR1 = nR1; eH2 = nH2; eR2 = nR2; eDup = nDup;
        eCnt = nCnt; eCnt2 = nCnt2;
    endtask

    task automatic clearModel();
        exRd = 0; memRd = 0; exLoad = 0; nExRd = 0; nMemRd = 0; nExLoad = 0;
        eH1 = 0; eR1 = 0; eH2 = 0; eR2 = 0; eDup = 0;
        nH1 = 0; nR1 = 0; nH2 = 0; nR2 = 0; nDup = 0;
        eSIf = 0; eSId = 0; eBub = 0; eFl = 0;
        eCnt = 0; eCnt2 = 0; nCnt = 0; nCnt2 = 0;
    endtask

    task automatic driveIdle();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = '0; id_regwrite = 0; id_op = '0; branch_taken = 0; mem_busy = 0;
    endtask

    task automatic applyStimulus(input int a1, input bit u1, input int a2, input bit u2,
                                 input int d, input bit w, input logic [6:0] o,
                                 input bit b, input bit m);
        @(posedge clk);
        commitModel();
        #1;
        id_rs1 = a1[4:0]; id_use_rs1 = u1;
        id_rs2 = a2[4:0]; id_use_rs2 = u2;
        id_rd = d[4:0]; id_regwrite = w; id_op = o;
        branch_taken = b; mem_busy = m;
        computeCycle();
    endtask

    task automatic nop();
        applyStimulus(0, 0, 0, 0, 0, 0, 7'd0, 0, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " is_hazard1"}, int'(is_hazard1), 0);
        checkOutput({tag, " is_hazard2"}, int'(is_hazard2), 0);
        checkOutput({tag, " hazard_reg1"}, int'(hazard_reg1), 0);
        checkOutput({tag, " hazard_reg2"}, int'(hazard_reg2), 0);
        checkOutput({tag, " dup_src"}, int'(dup_src), 0);
        checkOutput({tag, " stall_if"}, int'(stall_if), 0);
        checkOutput({tag, " stall_id"}, int'(stall_id), 0);
        checkOutput({tag, " bubble_ex"}, int'(bubble_ex), 0);
        checkOutput({tag, " flush_id"}, int'(flush_id), 0);
        checkOutput({tag, " stall_cnt"}, int'(stall_cnt), 0);
        checkOutput({tag, " stall_cnt small"}, int'(b_stall_cnt), 0);
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #1;
        rst = 0;
        driveIdle();
        computeCycle();
        checkEn = 1;
    endtask

    // Asynchronous reset asserted mid-cycle while the pipeline is frozen.
    task automatic doMidReset();
        checkEn = 0;
        #1;
        rst = 1;
        #1;
        checkAllZero("midreset");
        clearModel();
        driveIdle();
        releaseReset();
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("stall_if", int'(stall_if), eSIf);
            checkOutput("stall_id", int'(stall_id), eSId);
            checkOutput("bubble_ex", int'(bubble_ex), eBub);
            checkOutput("flush_id", int'(flush_id), eFl);
            checkOutput("is_hazard1", int'(is_hazard1), eH1);
            checkOutput("hazard_reg1", int'(hazard_reg1), eR1);
            checkOutput("is_hazard2", int'(is_hazard2), eH2);
            checkOutput("hazard_reg2", int'(hazard_reg2), eR2);
            checkOutput("dup_src", int'(dup_src), eDup);
            checkOutput("stall_cnt", int'(stall_cnt), eCnt);
            checkOutput("stall_cnt small", int'(b_stall_cnt), eCnt2);
            checkOutput("small stall_if", int'(b_stall_if), eSIf);
            checkOutput("small hazard_reg1", int'(b_hazard_reg1), eR1);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        releaseReset();

        // Distance-1 ALU dependence: addi x5 ; add x6,x5,x7
        applyStimulus(0, 1, 0, 0, 5, 1, OP_IMM, 0, 0);
        applyStimulus(5, 1, 7, 1, 6, 1, OP_ALU, 0, 0);
        #1 checkOutput("d1 no stall", int'(stall_if), 0);
        nop();
        #1;
        checkOutput("d1 is_hazard1", int'(is_hazard1), 1);
        checkOutput("d1 hazard_reg1", int'(hazard_reg1), 1);
        checkOutput("d1 is_hazard2", int'(is_hazard2), 0);

        // Distance-2 on rs2: addi x3 ; addi x9,x1 ; add x10,x1,x3
        applyStimulus(0, 1, 0, 0, 3, 1, OP_IMM, 0, 0);
        applyStimulus(1, 1, 0, 0, 9, 1, OP_IMM, 0, 0);
        applyStimulus(1, 1, 3, 1, 10, 1, OP_ALU, 0, 0);
        nop();
        #1;
        checkOutput("d2 is_hazard2", int'(is_hazard2), 1);
        checkOutput("d2 hazard_reg2", int'(hazard_reg2), 4);
        checkOutput("d2 is_hazard1", int'(is_hazard1), 0);

        // Producer in both slots: distance-1 wins, no distance-2 code
        applyStimulus(0, 1, 0, 0, 11, 1, OP_IMM, 0, 0);
        applyStimulus(0, 1, 0, 0, 11, 1, OP_IMM, 0, 0);
        applyStimulus(11, 1, 0, 1, 12, 1, OP_ALU, 0, 0);
        nop();
        #1;
        checkOutput("both hazard_reg1", int'(hazard_reg1), 1);
        checkOutput("both hazard_reg2", int'(hazard_reg2), 0);

        // rs1 from MEM, rs2 from EX
        applyStimulus(0, 1, 0, 0, 21, 1, OP_IMM, 0, 0);
        applyStimulus(0, 1, 0, 0, 22, 1, OP_IMM, 0, 0);
        applyStimulus(21, 1, 22, 1, 23, 1, OP_ALU, 0, 0);
        nop();
        #1;
        checkOutput("mix hazard_reg1", int'(hazard_reg1), 2);
        checkOutput("mix hazard_reg2", int'(hazard_reg2), 3);

        // Load-use: lw x4 ; sub x8,x4,x4 (held in ID for the bubble)
        applyStimulus(2, 1, 0, 0, 4, 1, OP_LOAD, 0, 0);
        applyStimulus(4, 1, 4, 1, 8, 1, OP_ALU, 0, 0);
        #1;
        checkOutput("lu stall_if", int'(stall_if), 1);
        checkOutput("lu bubble_ex", int'(bubble_ex), 1);
        checkOutput("lu cnt before", int'(stall_cnt), 0);
        applyStimulus(4, 1, 4, 1, 8, 1, OP_ALU, 0, 0);
        #1;
        checkOutput("lu cnt after", int'(stall_cnt), 1);
        checkOutput("lu stall released", int'(stall_if), 0);
        nop();
        #1;
        checkOutput("lu hazard_reg2", int'(hazard_reg2), 3);
        checkOutput("lu dup_src", int'(dup_src), 1);
        checkOutput("lu hazard_reg1", int'(hazard_reg1), 0);

        // Distance-2 load consumer costs no bubble
        applyStimulus(0, 1, 0, 0, 13, 1, OP_LOAD, 0, 0);
        applyStimulus(1, 1, 0, 0, 9, 1, OP_IMM, 0, 0);
        applyStimulus(13, 1, 0, 0, 24, 1, OP_ALU, 0, 0);
        #1 checkOutput("ld2 no stall", int'(stall_if), 0);
        nop();
        #1;
        checkOutput("ld2 hazard_reg2", int'(hazard_reg2), 3);
        checkOutput("ld2 cnt", int'(stall_cnt), 1);

        // Taken branch cancels a load-use and kills the wrong-path writer x15
        applyStimulus(0, 1, 0, 0, 14, 1, OP_LOAD, 0, 0);
        applyStimulus(14, 1, 0, 0, 15, 1, OP_ALU, 1, 0);
        #1;
        checkOutput("br flush_id", int'(flush_id), 1);
        checkOutput("br stall_if", int'(stall_if), 0);
        checkOutput("br bubble_ex", int'(bubble_ex), 1);
        applyStimulus(15, 1, 0, 0, 16, 1, OP_ALU, 0, 0);
        nop();
        #1;
        checkOutput("br wrongpath is_hazard1", int'(is_hazard1), 0);
        checkOutput("br wrongpath is_hazard2", int'(is_hazard2), 0);

        // Memory wait for 3 cycles (branch during the wait is ignored)
        applyStimulus(0, 1, 0, 0, 17, 1, OP_IMM, 0, 0);
        applyStimulus(17, 1, 0, 0, 18, 1, OP_ALU, 0, 0);
        applyStimulus(18, 1, 17, 1, 19, 1, OP_ALU, 0, 1);
        applyStimulus(18, 1, 17, 1, 19, 1, OP_ALU, 1, 1);
        #1 checkOutput("mw flush ignored", int'(flush_id), 0);
        applyStimulus(18, 1, 17, 1, 19, 1, OP_ALU, 0, 1);
        #1;
        checkOutput("mw stall_if", int'(stall_if), 1);
        checkOutput("mw bubble_ex", int'(bubble_ex), 0);
        checkOutput("mw held hazard_reg1", int'(hazard_reg1), 1);
        applyStimulus(18, 1, 17, 1, 19, 1, OP_ALU, 0, 0);
        #1;
        checkOutput("mw cnt", int'(stall_cnt), 5);
        checkOutput("mw cnt small sat", int'(b_stall_cnt), 3);
        nop();
        #1;
        checkOutput("mw resume hazard_reg1", int'(hazard_reg1), 1);
        checkOutput("mw resume hazard_reg2", int'(hazard_reg2), 4);

        // Writes to x0 never hazard, not even from a load
        applyStimulus(0, 1, 0, 0, 0, 1, OP_IMM, 0, 0);
        applyStimulus(0, 1, 0, 1, 20, 1, OP_ALU, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 1, OP_LOAD, 0, 0);
        applyStimulus(0, 1, 0, 1, 25, 1, OP_ALU, 0, 0);
        #1 checkOutput("x0 no stall", int'(stall_if), 0);
        nop();
        #1;
        checkOutput("x0 is_hazard1", int'(is_hazard1), 0);
        checkOutput("x0 is_hazard2", int'(is_hazard2), 0);

        // Reset while in MEMWAIT with live forwarding outputs
        applyStimulus(0, 1, 0, 0, 26, 1, OP_IMM, 0, 0);
        applyStimulus(26, 1, 0, 0, 27, 1, OP_ALU, 0, 0);
        applyStimulus(27, 1, 0, 0, 28, 1, OP_ALU, 0, 1);
        applyStimulus(27, 1, 0, 0, 28, 1, OP_ALU, 0, 1);
        doMidReset();

        // Normal operation after reset release
        applyStimulus(0, 1, 0, 0, 5, 1, OP_IMM, 0, 0);
        applyStimulus(5, 1, 0, 0, 6, 1, OP_ALU, 0, 0);
        nop();
        #1;
        checkOutput("post reset hazard_reg1", int'(hazard_reg1), 1);
        checkOutput("post reset cnt", int'(stall_cnt), 0);
        nop();
        nop();

        @(negedge clk);
        #1;
        checkEn = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
